// File: rtl/program_loader.sv
// Byte-stream program loader: hunts for a sync byte, reads a start address and
// word count, then writes little-endian STEP-byte words into instruction memory.
module program_loader #(
   parameter int          INSTR_ADDR_WIDTH = 20,
   parameter int          STEP             = 4,
   parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        abort,
   output logic                        pgm,
   output logic [INSTR_ADDR_WIDTH-1:0] addr,
   output logic [STEP*8-1:0]           data,
   output logic                        busy,
   output logic                        done
);

   localparam int ADDR_BYTES = (INSTR_ADDR_WIDTH + 7) / 8;
   localparam int AW         = ADDR_BYTES * 8;
   localparam int DW         = STEP * 8;

   localparam logic [7:0] LAST_ADDR = 8'(ADDR_BYTES - 1);
   localparam logic [7:0] LAST_STEP = 8'(STEP - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_CNT   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]                  state, next_state;
   logic [7:0]                  byte_cnt;
   logic [AW-1:0]               addr_buf, addr_next;
   logic [INSTR_ADDR_WIDTH-1:0] cur_addr;
   logic [15:0]                 cnt_buf, cnt_next;
   logic [DW-1:0]               word_buf, word_next;
   logic                        xfer;

   // Byte k of a multi-byte field lands in bits [8k+7:8k] (little-endian).
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      xfer      = in_valid && in_ready;
      addr_next = addr_buf;
      addr_next[{byte_cnt, 3'b000} +: 8] = in_data;
      word_next = word_buf;
      word_next[{byte_cnt, 3'b000} +: 8] = in_data;
      cnt_next  = {in_data, cnt_buf[15:8]};
      next_state = state;
      case (state)
         S_IDLE:  if (xfer && in_data == SYNC_BYTE) next_state = S_ADDR;
         S_ADDR:  if (xfer && byte_cnt == LAST_ADDR) next_state = S_CNT;
         S_CNT:   if (xfer && byte_cnt == 8'd1)
                     next_state = (cnt_next == 16'd0) ? S_DONE : S_DATA;
         S_DATA:  if (xfer && byte_cnt == LAST_STEP) next_state = S_WRITE;
         S_WRITE: next_state = (cnt_buf == 16'd1) ? S_DONE : S_DATA;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (abort && state != S_IDLE) next_state = S_IDLE;
   end

   // Outputs are registered from next_state so they line up with the state register.
   // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         byte_cnt <= 8'd0;
         addr_buf <= '0;
         cur_addr <= '0;
         cnt_buf  <= 16'd0;
         word_buf <= '0;
         in_ready <= 1'b0;
         pgm      <= 1'b0;
         addr     <= '0;
         data     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= next_state;
         in_ready <= (next_state == S_IDLE) || (next_state == S_ADDR) ||
                     (next_state == S_CNT)  || (next_state == S_DATA);
         busy     <= (next_state != S_IDLE);
         pgm      <= (next_state == S_WRITE);
         done     <= (next_state == S_DONE);

         if (abort && state != S_IDLE) begin
            byte_cnt <= 8'd0;
         end else begin
            case (state)
               S_IDLE: byte_cnt <= 8'd0;
               S_ADDR: if (xfer) begin
                  addr_buf <= addr_next;
                  if (byte_cnt == LAST_ADDR) begin
                     byte_cnt <= 8'd0;
                     cur_addr <= addr_next[INSTR_ADDR_WIDTH-1:0];
                  end else begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end
               S_CNT: if (xfer) begin
                  cnt_buf  <= cnt_next;
                  byte_cnt <= (byte_cnt == 8'd1) ? 8'd0 : byte_cnt + 8'd1;
               end
               S_DATA: if (xfer) begin
                  word_buf <= word_next;
                  if (byte_cnt == LAST_STEP) begin
                     byte_cnt <= 8'd0;
                     addr     <= cur_addr;
                     data     <= word_next;
                  end else begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end
               S_WRITE: begin
                  cur_addr <= cur_addr + 1'b1;
                  cnt_buf  <= cnt_buf - 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (8-bit word address, 4-byte words): a negedge
// monitor logs strobes/done/sync accepts; expectations are hand-computed constants.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        abort;
   logic        pgm;
   logic [7:0]  addr;
   logic [31:0] data;
   logic        busy;
   logic        done;

   program_loader #(
      .INSTR_ADDR_WIDTH(8),
      .STEP(4),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .abort(abort), .pgm(pgm), .addr(addr), .data(data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
      int          cyc;
   } wr_t;

   wr_t        wr_q[$];
   int         done_q[$];
   int         sync_q[$];
   int         cyc = 0;
   logic [7:0] seq[$];
   int         n_checks = 0;
   int         n_fail = 0;

   // Mid-cycle monitor: all DUT outputs and driven inputs are stable here.
   always @(negedge clk) begin
      if (pgm) wr_q.push_back('{a: addr, d: data, cyc: cyc});
      if (done) done_q.push_back(cyc);
      if (in_valid && in_ready && in_data == 8'hA5) sync_q.push_back(cyc);
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [7:0] a,
                           input logic [31:0] d);
      if (idx >= wr_q.size()) begin
         check({tag, "_present"}, 64'(wr_q.size()), 64'(idx + 1));
      end else begin
         check({tag, "_addr"}, 64'(wr_q[idx].a), 64'(a));
         check({tag, "_data"}, 64'(wr_q[idx].d), 64'(d));
      end
   endtask

   task automatic clear_sb();
      wr_q.delete();
      done_q.delete();
      sync_q.delete();
   endtask

   // Called just after a posedge; returns just after the posedge that took the byte.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 100) check("send_timeout_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_seq(input bit stall);
      foreach (seq[i]) begin
         if (stall && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
         send_byte(seq[i]);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int guard = 0;
      in_valid = 1'b0;
      @(negedge clk);
      while (busy && guard < 100) begin
         guard++;
         @(negedge clk);
      end
      check({tag, "_busy_fall"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic load_basic();
      seq = '{8'hA5, 8'h10, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("init_busy", 64'(busy), 64'd0);
      check("init_pgm", 64'(pgm), 64'd0);
      rst_n = 1'b1;

      // 1. Reset mid-DATA after one word has already been written.
      clear_sb();
      seq = '{8'hA5, 8'h10, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      send_seq(1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pgm", 64'(pgm), 64'd0);
      check("rst_addr", 64'(addr), 64'd0);
      check("rst_data", 64'(data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready_next", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      check("rst_writes", 64'(wr_q.size()), 64'd1);
      check("rst_no_done", 64'(done_q.size()), 64'd0);

      // 2. Basic two-word load.
      clear_sb();
      load_basic();
      send_seq(1'b0);
      wait_idle("basic");
      check("basic_writes", 64'(wr_q.size()), 64'd2);
      check_wr("basic_w0", 0, 8'h10, 32'h0000_0013);
      check_wr("basic_w1", 1, 8'h11, 32'h0010_0093);
      check("basic_done", 64'(done_q.size()), 64'd1);
      if (wr_q.size() == 2) check("basic_spacing", 64'(wr_q[1].cyc - wr_q[0].cyc), 64'd5);

      // 3. Sync hunt with random stalls.
      clear_sb();
      seq = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
      send_seq(1'b1);
      wait_idle("hunt");
      check("hunt_writes", 64'(wr_q.size()), 64'd2);
      check_wr("hunt_w0", 0, 8'h10, 32'h0000_0013);
      check_wr("hunt_w1", 1, 8'h11, 32'h0010_0093);
      check("hunt_done", 64'(done_q.size()), 64'd1);

      // 4a. Zero word count.
      clear_sb();
      seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_seq(1'b0);
      wait_idle("zero");
      check("zero_writes", 64'(wr_q.size()), 64'd0);
      check("zero_done", 64'(done_q.size()), 64'd1);

      // 4b. Address wrap from 0xFF to 0x00.
      clear_sb();
      seq = '{8'hA5, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88};
      send_seq(1'b0);
      wait_idle("wrap");
      check("wrap_writes", 64'(wr_q.size()), 64'd2);
      check_wr("wrap_w0", 0, 8'hFF, 32'h4433_2211);
      check_wr("wrap_w1", 1, 8'h00, 32'h8877_6655);

      // 5. Abort after two bytes of the second word, with a byte offered that cycle.
      clear_sb();
      seq = '{8'hA5, 8'h10, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      send_seq(1'b0);
      in_data = 8'h10; in_valid = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_pgm", 64'(pgm), 64'd0);
      idle(4);
      check("abort_writes", 64'(wr_q.size()), 64'd1);
      check_wr("abort_w0", 0, 8'h10, 32'h0000_0013);
      check("abort_no_done", 64'(done_q.size()), 64'd0);
      clear_sb();
      load_basic();
      send_seq(1'b0);
      wait_idle("post_abort");
      check("post_abort_writes", 64'(wr_q.size()), 64'd2);
      check_wr("post_abort_w0", 0, 8'h10, 32'h0000_0013);
      check_wr("post_abort_w1", 1, 8'h11, 32'h0010_0093);

      // 6. Back-to-back frames with in_valid held high throughout.
      clear_sb();
      seq = '{8'hA5, 8'h20, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'hA5, 8'h30, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08};
      send_seq(1'b0);
      wait_idle("b2b");
      check("b2b_writes", 64'(wr_q.size()), 64'd3);
      check_wr("b2b_w0", 0, 8'h20, 32'hDEAD_BEEF);
      check_wr("b2b_w1", 1, 8'h30, 32'h0403_0201);
      check_wr("b2b_w2", 2, 8'h31, 32'h0807_0605);
      check("b2b_done", 64'(done_q.size()), 64'd2);
      if (wr_q.size() == 3) check("b2b_spacing", 64'(wr_q[2].cyc - wr_q[1].cyc), 64'd5);
      check("b2b_syncs", 64'(sync_q.size()), 64'd2);
      if (sync_q.size() == 2 && done_q.size() >= 1)
         check("b2b_sync_after_done", 64'(sync_q[1] - done_q[0]), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream loader that writes program images into the instruction memory through its write port (pgm/addr/data).
- Receives a framed byte stream over a valid/ready handshake, typically from a UART receiver or debug bridge.
- Assembles bytes into STEP-byte instruction words and issues one single-cycle write strobe per word.
- Holds the core busy while loading and signals completion.

Parameters:
INSTR_ADDR_WIDTH  20  word-address width; must match the program memory
STEP  4  bytes per instruction word; data width is STEP*8
SYNC_BYTE  8'hA5  frame start marker
(derived localparam ADDR_BYTES = ceil(INSTR_ADDR_WIDTH/8))

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte; transfer when in_valid && in_ready
abort  input  1  synchronous abort of the current frame
pgm  output  1  memory write strobe, one cycle per word
addr  output  INSTR_ADDR_WIDTH  word address for the write
data  output  STEP*8  word for the write
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Frame format: SYNC_BYTE, then start address (ADDR_BYTES bytes, LE), then word count N (2 bytes, LE), then N*STEP data bytes.
- Address bits above INSTR_ADDR_WIDTH are discarded.
- Data byte k of a word goes to data[8k+7:8k] (little-endian).
- All outputs are registered.
- Reset (rst_n=0 at a posedge) clears everything, whatever the current state:
  - pgm=0, addr=0, data=0, busy=0, done=0, in_ready=0 for that cycle.
  - State goes to IDLE and the byte/word counters go to 0. No write occurs.
- States:
  - IDLE: in_ready=1. Accepted bytes other than SYNC_BYTE are discarded. Accepting SYNC_BYTE -> ADDR.
  - ADDR: accepts ADDR_BYTES bytes into the address register -> CNT.
  - CNT: accepts 2 bytes into the count register. If N==0 -> DONE, else -> DATA.
  - DATA: in_ready=1. Shifts in bytes; on the STEP-th accepted byte -> WRITE.
  - WRITE: in_ready=0, pgm=1 for exactly this cycle, with addr/data stable. On exit, addr increments (mod 2^INSTR_ADDR_WIDTH, silent wrap) and N decrements. If N becomes 0 -> DONE, else -> DATA.
  - DONE: in_ready=0, done=1 for one cycle -> IDLE.
- Throughput: one word per STEP+1 cycles with in_valid held high.
- in_valid low stalls any state without side effects. in_data is ignored when no transfer occurs.
- pgm is never asserted outside WRITE.
- addr/data hold their last values when pgm=0.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and the partial word is dropped.
  - No pgm and no done pulse.
  - Words already written stay written.
  - abort has priority over a byte accepted in the same cycle.
  - abort in IDLE has no effect.
- busy=1 in ADDR, CNT, DATA, WRITE, DONE.
- Back-to-back frames: a new SYNC_BYTE is accepted the cycle after DONE.

Test Plan (INSTR_ADDR_WIDTH=8, STEP=4, so ADDR_BYTES=1):
1. Reset: hold rst_n=0 for 3 cycles mid-DATA with pgm high in previous history -> after reset pgm=0, addr=0, data=0, busy=0, done=0; next cycle in_ready=1.
2. Basic load: stream A5,10,02,00,13,00,00,00,93,00,10,00 -> pgm pulses at addr=0x10 data=0x00000013 and at addr=0x11 data=0x00100093, exactly one cycle each; then done pulses once and busy falls.
3. Sync hunt and stalls: stream 00,FF,A5,... with in_valid randomly low -> leading bytes ignored; writes identical to scenario 2; no pgm while stalled.
4. Zero count and wrap: frame A5,00,00,00 -> done with no pgm. Frame A5,FF,02,00 plus 8 data bytes -> writes at addr 0xFF then 0x00.
5. Abort: abort asserted after 2 data bytes of the second word in scenario 2 -> only the first write occurs, no done, busy=0 next cycle. A following full frame loads correctly.
6. Back-to-back frames with in_valid held high -> second SYNC_BYTE accepted the cycle after done. The write count equals the total N of both frames, and the spacing between strobes is 5 cycles.
